// File: rtl/xbus_arbiter_if.sv
// Two-master xbus bundle: master request/grant/ack side plus the shared slave bus.
// The arbiter uses the master modport; the environment uses the slave modport.
interface xbus_arbiter_if;
    logic        m0_req;
    logic [21:0] m0_addr;
    logic [31:0] m0_data;
    logic        m0_write;
    logic        m0_grant;
    logic        m0_ack;
    logic        m1_req;
    logic [21:0] m1_addr;
    logic [31:0] m1_data;
    logic        m1_write;
    logic        m1_grant;
    logic        m1_ack;
    logic        m_err;
    logic [31:0] m_rdata;
    logic        bus_req;
    logic [21:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_write;
    logic        bus_decode;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  m0_req, m0_addr, m0_data, m0_write,
        input  m1_req, m1_addr, m1_data, m1_write,
        output m0_grant, m0_ack, m1_grant, m1_ack,
        output m_err, m_rdata,
        output bus_req, bus_addr, bus_data, bus_write,
        input  bus_decode, bus_ack, bus_rdata
    );

    modport slave (
        output m0_req, m0_addr, m0_data, m0_write,
        output m1_req, m1_addr, m1_data, m1_write,
        input  m0_grant, m0_ack, m1_grant, m1_ack,
        input  m_err, m_rdata,
        input  bus_req, bus_addr, bus_data, bus_write,
        output bus_decode, bus_ack, bus_rdata
    );
endinterface

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter sharing the xbus slave side between CPU (m0) and disk DMA (m1).
// Unclaimed addresses complete with m_err after a decode timeout.
module xbus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset_n,
    xbus_arbiter_if.master xb
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic          r_sel;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_claimed;
    logic          r_m0_grant;
    logic          r_m1_grant;
    logic          r_m0_ack;
    logic          r_m1_ack;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_bus_req;
    logic [21:0]   r_addr;
    logic [31:0]   r_data;
    logic          r_write;

    logic w_any;
    logic w_pick;
    logic w_expire;

    assign w_any = xb.m0_req | xb.m1_req;

    // On a tie the master not served last wins; otherwise the lone requester.
    assign w_pick = (xb.m0_req & xb.m1_req) ? ~r_last : xb.m1_req;

    // A slave that has decoded owns completion, so only unclaimed cycles time out.
    assign w_expire = ~r_claimed & ~xb.bus_decode & (r_cnt == C_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_claimed  <= 1'b0;
            r_m0_grant <= 1'b0;
            r_m1_grant <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_bus_req  <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_write    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state    <= S_BUSY;
                        r_sel      <= w_pick;
                        r_m0_grant <= ~w_pick;
                        r_m1_grant <= w_pick;
                        r_bus_req  <= 1'b1;
                        r_addr     <= w_pick ? xb.m1_addr  : xb.m0_addr;
                        r_data     <= w_pick ? xb.m1_data  : xb.m0_data;
                        r_write    <= w_pick ? xb.m1_write : xb.m0_write;
                        r_cnt      <= '0;
                        r_claimed  <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (!xb.bus_decode && r_cnt != C_LIMIT) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                    if (xb.bus_decode) begin
                        r_claimed <= 1'b1;
                    end
                    if (xb.bus_ack || w_expire) begin
                        r_state    <= S_DONE;
                        r_bus_req  <= 1'b0;
                        r_m0_grant <= 1'b0;
                        r_m1_grant <= 1'b0;
                        r_m0_ack   <= ~r_sel;
                        r_m1_ack   <= r_sel;
                    end
                    if (xb.bus_ack) begin
                        r_err <= 1'b0;
                        if (!r_write) begin
                            r_rdata <= xb.bus_rdata;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                    r_err    <= 1'b0;
                    r_last   <= r_sel;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign xb.m0_grant  = r_m0_grant;
    assign xb.m1_grant  = r_m1_grant;
    assign xb.m0_ack    = r_m0_ack;
    assign xb.m1_ack    = r_m1_ack;
    assign xb.m_err     = r_err;
    assign xb.m_rdata   = r_rdata;
    assign xb.bus_req   = r_bus_req;
    assign xb.bus_addr  = r_addr;
    assign xb.bus_data  = r_data;
    assign xb.bus_write = r_write;
endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed and randomized bench for xbus_arbiter with a transaction-level model
// and a simple slave that claims the upper address range.
module tb_xbus_arbiter;
    localparam int TO = 16;
    localparam logic [21:0] MAP_BASE = 22'o17000000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    int vectors = 0;
    int miscompares = 0;

    xbus_arbiter_if xb ();

    xbus_arbiter #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .xb      (xb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave: decodes mapped range, acks ack_lat cycles after decode starts.
    logic [31:0] s_rdata = 32'h0;
    int          ack_lat = 1;
    int          dcnt = 0;
    logic        s_mapped;

    assign s_mapped      = xb.bus_addr >= MAP_BASE;
    assign xb.bus_decode = xb.bus_req && s_mapped;
    assign xb.bus_ack    = xb.bus_decode && (dcnt == ack_lat);
    assign xb.bus_rdata  = xb.bus_ack ? s_rdata : 32'h0;

    always @(posedge clk) begin
        if (!xb.bus_req) dcnt <= 0;
        else if (xb.bus_decode) dcnt <= dcnt + 1;
    end

    // Model state.
    bit          last_m = 1'b1;
    logic [31:0] mdl_rdata = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {xb.m0_grant, xb.m1_grant, xb.m0_ack, xb.m1_ack,
                        xb.m_err, xb.bus_req, xb.bus_write}, 64'h0);
        chk("rst_rdata", xb.m_rdata, 64'h0);
        chk("rst_bus", {xb.bus_addr, xb.bus_data}, 64'h0);
        last_m = 1'b1;
        mdl_rdata = 32'h0;
        reset_n = 1'b1;
    endtask

    task automatic set_m(input bit m, input logic [21:0] a,
                         input logic [31:0] d, input bit w);
        if (m) begin
            xb.m1_req = 1'b1; xb.m1_addr = a;
            xb.m1_data = d;   xb.m1_write = w;
        end else begin
            xb.m0_req = 1'b1; xb.m0_addr = a;
            xb.m0_data = d;   xb.m0_write = w;
        end
    endtask

    // Called at negedge of an IDLE cycle with requests already posted.
    task automatic serve(input bit h0, input bit h1, input bit mutate,
                         output int gcyc);
        bit          w;
        logic [21:0] a;
        logic [31:0] d;
        bit          wr;
        bit          mp;
        int          exp_k;
        logic [31:0] exp_rd;
        bit          got;
        int          kk;
        w  = (xb.m0_req && xb.m1_req) ? !last_m : xb.m1_req;
        a  = w ? xb.m1_addr  : xb.m0_addr;
        d  = w ? xb.m1_data  : xb.m0_data;
        wr = w ? xb.m1_write : xb.m0_write;
        mp = a >= MAP_BASE;
        exp_k  = mp ? ack_lat + 2 : TO + 2;
        exp_rd = !mp ? 32'h0 : (wr ? mdl_rdata : s_rdata);
        got = 1'b0;
        kk = 0;
        gcyc = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                gcyc = cyc;
                chk("busy_req", xb.bus_req, 64'h1);
                chk("busy_grant", {xb.m1_grant, xb.m0_grant},
                    w ? 64'h2 : 64'h1);
                chk("busy_bus", {wr, d, a}, {xb.bus_write, xb.bus_data,
                                             xb.bus_addr});
                if (mutate) begin
                    if (w) xb.m1_addr = ~a;
                    else   xb.m0_addr = ~a;
                end
            end
            if (k == exp_k - 1 && k > 1) begin
                chk("hold_addr", xb.bus_addr, a);
            end
            if (xb.m0_ack || xb.m1_ack) begin
                got = 1'b1;
                kk = k;
                break;
            end
        end
        chk("ack_seen", got, 64'h1);
        if (got) begin
            chk("ack_lat", kk, exp_k);
            chk("done_ack", {xb.m1_ack, xb.m0_ack, xb.m1_grant,
                             xb.m0_grant, xb.bus_req}, w ? 64'h10 : 64'h8);
            chk("done_err", xb.m_err, !mp);
            chk("done_rdata", xb.m_rdata, exp_rd);
            last_m = w;
            mdl_rdata = exp_rd;
            if (!w && !h0) xb.m0_req = 1'b0;
            if (w && !h1) xb.m1_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("idle_clr", {xb.m_err, xb.m0_ack, xb.m1_ack}, 64'h0);
        end
    endtask

    initial begin : main
        int g [0:4];
        int gd;
        bit seen;
        xb.m0_req = 1'b0; xb.m0_addr = '0; xb.m0_data = '0; xb.m0_write = 1'b0;
        xb.m1_req = 1'b0; xb.m1_addr = '0; xb.m1_data = '0; xb.m1_write = 1'b0;
        @(negedge clk);
        do_reset();

        // m0 read of a mapped register.
        ack_lat = 1;
        s_rdata = 32'h1234;
        set_m(1'b0, 22'o17377775, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 1'b0, gd);

        // m1 write; m_rdata must keep the earlier read value.
        s_rdata = 32'hFFFF_0000;
        set_m(1'b1, 22'o17377776, 32'hDEAD, 1'b1);
        serve(1'b0, 1'b0, 1'b0, gd);

        // Unmapped read times out.
        set_m(1'b0, 22'o00001000, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 1'b0, gd);

        // Slow slave past the timeout window: decode suppresses the error.
        ack_lat = TO + 4;
        s_rdata = 32'h5A5A_0001;
        set_m(1'b1, 22'o17400000, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 1'b0, gd);
        ack_lat = 1;

        // Address change during BUSY is ignored.
        s_rdata = 32'h0BAD_F00D;
        set_m(1'b0, 22'o17377770, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 1'b1, gd);

        // Both masters held high from reset: strict alternation, 4 cycles apart.
        set_m(1'b0, 22'o17000010, 32'h11, 1'b0);
        set_m(1'b1, 22'o17000020, 32'h22, 1'b1);
        do_reset();
        s_rdata = 32'hCAFE_0003;
        serve(1'b1, 1'b1, 1'b0, g[0]);
        serve(1'b1, 1'b1, 1'b0, g[1]);
        serve(1'b1, 1'b1, 1'b0, g[2]);
        serve(1'b1, 1'b0, 1'b0, g[3]);
        serve(1'b0, 1'b0, 1'b0, g[4]);
        for (int i = 1; i < 5; i++) begin
            chk("grant_gap", g[i] - g[i-1], 64'd4);
        end

        // Reset during m1 BUSY aborts without an ack.
        set_m(1'b1, 22'o17377776, 32'h77, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {xb.bus_req, xb.m1_grant}, 64'h3);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ctl", {xb.m0_grant, xb.m1_grant, xb.m0_ack, xb.m1_ack,
                          xb.m_err, xb.bus_req, xb.bus_write}, 64'h0);
        chk("abort_bus", {xb.bus_addr, xb.bus_data}, 64'h0);
        chk("abort_rdata", xb.m_rdata, 64'h0);
        reset_n = 1'b1;
        xb.m1_req = 1'b0;
        last_m = 1'b1;
        mdl_rdata = 32'h0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | xb.m0_ack | xb.m1_ack;
        end
        chk("abort_noack", seen, 64'h0);
        s_rdata = 32'h0000_BEEF;
        set_m(1'b0, 22'o17377775, 32'h0, 1'b0);
        serve(1'b0, 1'b0, 1'b0, gd);

        // Randomized traffic; a loser keeps its pending request.
        for (int n = 0; n < 40; n++) begin
            for (int m = 0; m < 2; m++) begin
                bit pend;
                pend = m ? xb.m1_req : xb.m0_req;
                if (!pend && $urandom_range(0, 1) == 1) begin
                    logic [21:0] a;
                    if ($urandom_range(0, 99) < 85)
                        a = MAP_BASE + 22'($urandom_range(0, 22'o777777));
                    else
                        a = 22'($urandom_range(0, 22'o16777777));
                    set_m(m[0], a, $urandom, 1'($urandom_range(0, 1)));
                end
            end
            if (!xb.m0_req && !xb.m1_req) begin
                set_m(1'b0, MAP_BASE + 22'($urandom_range(0, 4095)),
                      $urandom, 1'b0);
            end
            ack_lat = $urandom_range(1, 3);
            s_rdata = $urandom;
            serve(1'b0, 1'b0, 1'b0, gd);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
